// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline stage registers: occupancy-coded states and
// the default bubble encoding.
package pipe_stage_reg_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

   localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// One instruction/PC holding register with load enable and synchronous clear
// back to the bubble encoding.
module pipe_entry_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                 INSTR_W   = 16,
   parameter int                 PC_W      = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               load,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [PC_W-1:0]    d_pc,
   output logic [INSTR_W-1:0] q_instr,
   output logic [PC_W-1:0]    q_pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_instr <= NOP_INSTR;
         q_pc    <= '0;
      end else if (clear) begin
         q_instr <= NOP_INSTR;
         q_pc    <= '0;
      end else if (load) begin
         q_instr <= d_instr;
         q_pc    <= d_pc;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline stage: main register drives the outputs, skid register
// catches the one entry accepted while downstream stalls.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int                 INSTR_W   = 16,
   parameter int                 PC_W      = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
   parameter int                 CNT_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   stage_state_t       state, state_next;
   logic               in_fire, out_fire;
   logic               main_load, main_clear, main_sel_skid;
   logic               skid_load;
   logic [INSTR_W-1:0] skid_instr, main_d_instr;
   logic [PC_W-1:0]    skid_pc, main_d_pc;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_valid = (state != ST_EMPTY);
   assign occupancy = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_next;
   end

   // in_ready is a flop on the next state so out_ready never reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_ready <= 1'b0;
      else     in_ready <= (state_next != ST_TWO);
   end

   always_comb begin
      state_next    = state;
      main_load     = 1'b0;
      main_clear    = flush;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_next = ST_ONE;
                  main_load  = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire) begin
                  state_next = ST_TWO;
                  skid_load  = 1'b1;
               end else if (out_fire) begin
                  // Drained: clear main so the outputs show a bubble while empty.
                  state_next = ST_EMPTY;
                  main_clear = 1'b1;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  state_next    = ST_ONE;
                  main_load     = 1'b1;
                  main_sel_skid = 1'b1;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   assign main_d_instr = main_sel_skid ? skid_instr : in_instr;
   assign main_d_pc    = main_sel_skid ? skid_pc    : in_pc;

   pipe_entry_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_main (
      .clk     (clk),
      .rst     (rst),
      .clear   (main_clear),
      .load    (main_load),
      .d_instr (main_d_instr),
      .d_pc    (main_d_pc),
      .q_instr (out_instr),
      .q_pc    (out_pc)
   );

   pipe_entry_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .load    (skid_load),
      .d_instr (in_instr),
      .d_pc    (in_pc),
      .q_instr (skid_instr),
      .q_pc    (skid_pc)
   );

   // Saturating count of back-pressured cycles; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction field width.
REQ-002 SHALL have parameter PC_W, default 16, PC field width.
REQ-003 SHALL have parameter NOP_INSTR, default 16'h0000 (INSTR_W bits), the bubble encoding.
REQ-004 SHALL have parameter CNT_W, default 8, stall-counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-006 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  async reset, active-high
- flush  in  1  discard all held entries
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage accepts entry this cycle
- in_instr  in  INSTR_W  upstream instruction
- in_pc  in  PC_W  upstream PC
- out_valid  out  1  downstream entry present
- out_ready  in  1  downstream accepts entry
- out_instr  out  INSTR_W  held instruction
- out_pc  out  PC_W  held PC
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Function
REQ-007 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; all state updates on rising clk.
REQ-008 SHALL implement a 2-entry skid stage: main register drives out_*, skid register absorbs one entry while downstream stalls.
REQ-009 SHALL use states EMPTY (occ 0), ONE (occ 1), TWO (occ 2); occupancy SHALL equal state encoding 0/1/2.
REQ-010 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, registered (no combinational path from out_ready).
REQ-011 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-012 EMPTY: in_fire -> ONE, main <= in; else stay.
REQ-013 ONE: in_fire & out_fire -> ONE, main <= in; in_fire & ~out_fire -> TWO, skid <= in; ~in_fire & out_fire -> EMPTY; else hold.
REQ-014 TWO: out_fire -> ONE, main <= skid; else hold all contents.
REQ-015 Order SHALL be preserved; no entry dropped or duplicated absent flush.
REQ-016 In EMPTY, out_instr SHALL equal NOP_INSTR and out_pc SHALL equal 0.
REQ-017 flush SHALL take priority over every other event: next state EMPTY, main/skid cleared to NOP_INSTR/0, same-cycle in_fire and out_fire data discarded (upstream treats in_fire as consumed).
REQ-018 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and not change otherwise; flush SHALL NOT clear it.
REQ-019 Latency in_fire to out_valid SHALL be 1 cycle from EMPTY; full throughput (one entry/cycle) when out_ready held 1.

Reset
REQ-020 rst=1 SHALL asynchronously force state EMPTY, main/skid to NOP_INSTR/0, stall_cnt 0.
REQ-021 During reset: in_ready=0, out_valid=0, out_instr=NOP_INSTR, out_pc=0, occupancy=0; in_ready SHALL become 1 on the first rising clk after rst deasserts.
REQ-022 Reset mid-transfer SHALL drop all held entries without partial updates.

Structure
REQ-023 State encoding (EMPTY/ONE/TWO) and NOP_INSTR default SHALL live in a shared pipeline package used by all stage registers.
REQ-024 A sub-module pipe_entry_reg (one INSTR_W+PC_W register with load enable and clear) SHALL be instantiated twice, for main and skid.

Verification
REQ-025 Reset then in_valid=1, instr=16'hA123, pc=16'h0004, out_ready=1 -> next cycle out_valid=1, out_instr=16'hA123, out_pc=16'h0004, occupancy=1.
REQ-026 out_ready=0, feed 16'h1111 then 16'h2222 -> occupancy=2, in_ready=0, out_instr=16'h1111; raise out_ready -> 16'h1111 then 16'h2222 in order, in_ready=1 after first out_fire.
REQ-027 occupancy=2 plus flush=1 and in_valid=1 same cycle -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, input discarded.
REQ-028 CNT_W=2, out_valid=1, out_ready=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3.
REQ-029 rst asserted mid-cycle with occupancy=2 -> outputs immediately reset values without a clock edge; in_ready=1 one edge after release.
REQ-030 Random in_valid/out_ready streams of 1000 entries -> output sequence identical to input sequence, occupancy never exceeds 2.
